// File: rtl/cp_pkg.sv
// Shared types and helpers for the convolution control-path sequencer.
package cp_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWeights = 3'd1,
    StData    = 3'd2,
    StResult  = 3'd3,
    StDone    = 3'd4
  } cp_state_e;

  // A zero count means one; anything above the maximum saturates to it.
  function automatic int unsigned clamp_cfg(input int unsigned val, input int unsigned max_val);
    if (val == 0) return 1;
    if (val > max_val) return max_val;
    return val;
  endfunction

endpackage

// File: rtl/cp_watchdog.sv
// Per-state cycle counter that pulses timeout_o in its last permitted cycle.
module cp_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic timeout_o
);

  localparam logic [CntW-1:0] Last = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i) begin
      cnt_d = '0;
    end else if (cnt_q != Last) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == Last);

endmodule

// File: rtl/cp_sequencer.sv
// Sequences WEIGHTS -> DATA -> RESULT over configurable blocks and channels,
// with edge-triggered start, abort, continuous mode and a watchdog.
module cp_sequencer
  import cp_pkg::*;
#(
  parameter int unsigned MAX_BLOCKS     = 16,
  parameter int unsigned MAX_CHANNELS   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned BLK_W          = $clog2(MAX_BLOCKS + 1),
  parameter int unsigned CH_W           = $clog2(MAX_CHANNELS + 1),
  localparam int unsigned BIdxW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1,
  localparam int unsigned CIdxW = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             cont_mode_i,
  input  logic [BLK_W-1:0] cfg_blocks_i,
  input  logic [CH_W-1:0]  cfg_channels_i,
  input  logic             weights_pulled_i,
  input  logic             data_sent_i,
  input  logic             result_done_i,
  output logic             weights_o,
  output logic             data_o,
  output logic             result_o,
  output logic [BIdxW-1:0] block_idx_o,
  output logic [CIdxW-1:0] chan_idx_o,
  output logic             image_done_o,
  output logic             busy_o,
  output logic             error_o
);

  cp_state_e        state_q, state_d;
  logic [BIdxW-1:0] blk_q, blk_d, last_blk_q, last_blk_d, lat_blk;
  logic [CIdxW-1:0] ch_q, ch_d, last_ch_q, last_ch_d, lat_ch;
  logic             error_q, error_d;
  logic             enable_q;
  logic             weights_q, weights_d, data_q, data_d, result_q, result_d;
  logic             done_q, done_d, busy_q, busy_d;
  logic             start, in_hs, timeout;

  assign start   = enable_i & ~enable_q;
  assign in_hs   = (state_q == StWeights) || (state_q == StData) || (state_q == StResult);
  // Stored as last index so the compare needs no extra bit.
  assign lat_blk = BIdxW'(clamp_cfg(32'(cfg_blocks_i), MAX_BLOCKS) - 1);
  assign lat_ch  = CIdxW'(clamp_cfg(32'(cfg_channels_i), MAX_CHANNELS) - 1);

  cp_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (state_d != state_q),
    .enable_i (in_hs),
    .timeout_o(timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      blk_q      <= '0;
      ch_q       <= '0;
      last_blk_q <= '0;
      last_ch_q  <= '0;
      error_q    <= 1'b0;
      enable_q   <= 1'b0;
      weights_q  <= 1'b0;
      data_q     <= 1'b0;
      result_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      ch_q       <= ch_d;
      last_blk_q <= last_blk_d;
      last_ch_q  <= last_ch_d;
      error_q    <= error_d;
      enable_q   <= enable_i;
      weights_q  <= weights_d;
      data_q     <= data_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    ch_d       = ch_q;
    last_blk_d = last_blk_q;
    last_ch_d  = last_ch_q;
    error_d    = error_q;
    // Abort outranks handshakes and the watchdog in every handshake state.
    if (in_hs && !enable_i) begin
      state_d = StIdle;
      blk_d   = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StWeights;
            last_blk_d = lat_blk;
            last_ch_d  = lat_ch;
            error_d    = 1'b0;
            blk_d      = '0;
            ch_d       = '0;
          end
        end
        StWeights: begin
          if (weights_pulled_i) state_d = StData;
          else if (timeout) begin
            state_d = StIdle;
            error_d = 1'b1;
            blk_d   = '0;
            ch_d    = '0;
          end
        end
        StData: begin
          if (data_sent_i) state_d = StResult;
          else if (timeout) begin
            state_d = StIdle;
            error_d = 1'b1;
            blk_d   = '0;
            ch_d    = '0;
          end
        end
        StResult: begin
          if (result_done_i) begin
            if (blk_q < last_blk_q) begin
              blk_d   = blk_q + BIdxW'(1);
              state_d = StData;
            end else if (ch_q < last_ch_q) begin
              ch_d    = ch_q + CIdxW'(1);
              blk_d   = '0;
              state_d = StWeights;
            end else begin
              state_d = StDone;
            end
          end else if (timeout) begin
            state_d = StIdle;
            error_d = 1'b1;
            blk_d   = '0;
            ch_d    = '0;
          end
        end
        StDone: begin
          blk_d = '0;
          ch_d  = '0;
          if (cont_mode_i && enable_i) begin
            state_d    = StWeights;
            last_blk_d = lat_blk;
            last_ch_d  = lat_ch;
          end else begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          blk_d   = '0;
          ch_d    = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    weights_d = (state_d == StWeights);
    data_d    = (state_d == StData);
    result_d  = (state_d == StResult);
    done_d    = (state_d == StDone);
    busy_d    = (state_d != StIdle);
  end

  assign weights_o    = weights_q;
  assign data_o       = data_q;
  assign result_o     = result_q;
  assign image_done_o = done_q;
  assign busy_o       = busy_q;
  assign error_o      = error_q;
  assign block_idx_o  = blk_q;
  assign chan_idx_o   = ch_q;

endmodule
